// File: rtl/pong_pkg.sv
// Shared pong definitions: direction encodings, ball FSM state encoding and
// default screen/paddle geometry used by the ball motion controller.
package pong_pkg;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  localparam int PONG_H_ACTIVE  = 640;
  localparam int PONG_V_ACTIVE  = 480;
  localparam int PONG_BALL_SIZE = 8;
  localparam int PONG_PADDLE_W  = 8;
  localparam int PONG_PADDLE_H  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    MISS = 2'd2
  } ball_state_t;

endpackage

// File: rtl/axis_stepper.sv
// One axis of ball motion: position, direction, wall clamp and edge detect.
// dir=1 moves toward LO_LIM (LEFT/UP), dir=0 toward HI_LIM (RIGHT/DOWN).
module axis_stepper #(
  parameter int   COORD_W   = 10,
  parameter int   STEP_W    = 3,
  parameter int   LO_LIM    = 0,
  parameter int   HI_LIM    = 472,
  parameter int   CENTER    = 236,
  parameter logic RESET_DIR = 1'b0
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               adv,
  input  logic [STEP_W-1:0]  step,
  input  logic               hit_lo,
  input  logic               hit_hi,
  input  logic               force_en,
  input  logic               force_dir,
  input  logic               load,
  input  logic               load_dir_en,
  input  logic               load_dir,
  output logic [COORD_W-1:0] pos,
  output logic               dir,
  output logic               miss_lo,
  output logic               miss_hi
);

  localparam int XW = COORD_W + 1;

  logic [XW-1:0]      pos_x;
  logic [XW-1:0]      step_x;
  logic               cross_lo;
  logic               cross_hi;
  logic [COORD_W-1:0] pos_nxt;
  logic               dir_nxt;

  // One spare bit so pos-step and pos+step never wrap.
  assign pos_x    = {1'b0, pos};
  assign step_x   = XW'(step);
  assign cross_lo = dir && (pos_x < XW'(LO_LIM) + step_x);
  assign cross_hi = !dir && (pos_x + step_x > XW'(HI_LIM));
  assign miss_lo  = adv && cross_lo && !hit_lo;
  assign miss_hi  = adv && cross_hi && !hit_hi;

  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    if (load) begin
      pos_nxt = COORD_W'(CENTER);
      if (load_dir_en) dir_nxt = load_dir;
    end else if (adv) begin
      if (cross_lo) begin
        if (hit_lo) begin
          pos_nxt = COORD_W'(LO_LIM);
          dir_nxt = 1'b0;
        end
      end else if (cross_hi) begin
        if (hit_hi) begin
          pos_nxt = COORD_W'(HI_LIM);
          dir_nxt = 1'b1;
        end
      end else if (dir) begin
        pos_nxt = pos - COORD_W'(step);
      end else begin
        pos_nxt = pos + COORD_W'(step);
      end
      if (force_en) dir_nxt = force_dir;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      pos <= COORD_W'(CENTER);
      dir <= RESET_DIR;
    end else begin
      pos <= pos_nxt;
      dir <= dir_nxt;
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball position/direction, wall and paddle collisions, serve/play/miss FSM.
// Define DEBUG_DIR_OVERRIDE_EN to add the i_Switch direction override port.
//
// state | meaning
// IDLE  | ball centred and hidden, waiting for i_Serve on a frame tick
// MOVE  | ball in play, stepped once per frame tick
// MISS  | ball hidden and frozen for MISS_FRAMES ticks, then recentred
module ball_motion_ctrl
  import pong_pkg::*;
#(
  parameter int H_ACTIVE    = PONG_H_ACTIVE,
  parameter int V_ACTIVE    = PONG_V_ACTIVE,
  parameter int COORD_W     = 10,
  parameter int BALL_SIZE   = PONG_BALL_SIZE,
  parameter int PADDLE_W    = PONG_PADDLE_W,
  parameter int PADDLE_H    = PONG_PADDLE_H,
  parameter int STEP_W      = 3,
  parameter int MISS_FRAMES = 60
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
`ifdef DEBUG_DIR_OVERRIDE_EN
  input  logic [3:0]         i_Switch,
`endif
  input  logic               i_Frame_Tick,
  input  logic               i_Serve,
  input  logic [STEP_W-1:0]  i_Speed,
  input  logic [COORD_W-1:0] i_PaddleL_Y,
  input  logic [COORD_W-1:0] i_PaddleR_Y,
  output logic [COORD_W-1:0] o_Ball_X,
  output logic [COORD_W-1:0] o_Ball_Y,
  output logic               o_HDir,
  output logic               o_VDir,
  output logic               o_Active,
  output logic               o_Score_L,
  output logic               o_Score_R
);

  localparam int CX    = (H_ACTIVE - BALL_SIZE) / 2;
  localparam int CY    = (V_ACTIVE - BALL_SIZE) / 2;
  localparam int X_LO  = PADDLE_W;
  localparam int X_HI  = H_ACTIVE - PADDLE_W - BALL_SIZE;
  localparam int Y_HI  = V_ACTIVE - BALL_SIZE;
  localparam int XW    = COORD_W + 1;
  localparam int CNT_W = $clog2(MISS_FRAMES + 1);

  ball_state_t       state;
  ball_state_t       state_nxt;
  logic [STEP_W-1:0] step;
  logic [CNT_W-1:0]  miss_cnt;
  logic              loser_left;
  logic              serve_go;
  logic              move_tick;
  logic              miss_done;
  logic              recenter;
  logic [XW-1:0]     y_x;
  logic              overlap_l;
  logic              overlap_r;
  logic              miss_l;
  logic              miss_r;
  logic [1:0]        y_miss_unused;
  logic              force_en;
  logic              force_h;
  logic              force_v;
  logic              active_nxt;
  logic              score_l_nxt;
  logic              score_r_nxt;

  assign serve_go  = (state == IDLE) && i_Frame_Tick && i_Serve;
  assign move_tick = (state == MOVE) && i_Frame_Tick;
  assign miss_done = (miss_cnt == '0);
  assign recenter  = (state == MISS) && i_Frame_Tick && miss_done;

  // Paddle overlap is judged on the ball's pre-update line.
  assign y_x       = {1'b0, o_Ball_Y};
  assign overlap_l = (y_x + XW'(BALL_SIZE) > {1'b0, i_PaddleL_Y}) &&
                     (y_x < {1'b0, i_PaddleL_Y} + XW'(PADDLE_H));
  assign overlap_r = (y_x + XW'(BALL_SIZE) > {1'b0, i_PaddleR_Y}) &&
                     (y_x < {1'b0, i_PaddleR_Y} + XW'(PADDLE_H));

`ifdef DEBUG_DIR_OVERRIDE_EN
  always_comb begin
    force_en = |i_Switch;
    force_h  = DIR_LEFT;
    force_v  = DIR_UP;
    if (i_Switch[3]) begin
      force_h = DIR_RIGHT;
      force_v = DIR_DOWN;
    end else if (i_Switch[2]) begin
      force_h = DIR_RIGHT;
      force_v = DIR_UP;
    end else if (i_Switch[1]) begin
      force_h = DIR_LEFT;
      force_v = DIR_DOWN;
    end
  end
`else
  assign force_en = 1'b0;
  assign force_h  = DIR_RIGHT;
  assign force_v  = DIR_DOWN;
`endif

  axis_stepper #(
    .COORD_W(COORD_W), .STEP_W(STEP_W), .LO_LIM(X_LO), .HI_LIM(X_HI),
    .CENTER(CX), .RESET_DIR(DIR_RIGHT)
  ) u_x_axis (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .adv(move_tick), .step(step),
    .hit_lo(overlap_l), .hit_hi(overlap_r),
    .force_en(force_en), .force_dir(force_h),
    .load(recenter), .load_dir_en(1'b1),
    .load_dir(loser_left ? DIR_LEFT : DIR_RIGHT),
    .pos(o_Ball_X), .dir(o_HDir), .miss_lo(miss_l), .miss_hi(miss_r)
  );

  // Vertical walls always reflect, so this axis never reports a miss.
  axis_stepper #(
    .COORD_W(COORD_W), .STEP_W(STEP_W), .LO_LIM(0), .HI_LIM(Y_HI),
    .CENTER(CY), .RESET_DIR(DIR_UP)
  ) u_y_axis (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .adv(move_tick), .step(step),
    .hit_lo(1'b1), .hit_hi(1'b1),
    .force_en(force_en), .force_dir(force_v),
    .load(recenter), .load_dir_en(1'b0), .load_dir(DIR_UP),
    .pos(o_Ball_Y), .dir(o_VDir),
    .miss_lo(y_miss_unused[0]), .miss_hi(y_miss_unused[1])
  );

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state     <= IDLE;
      o_Active  <= 1'b0;
      o_Score_L <= 1'b0;
      o_Score_R <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_Active  <= active_nxt;
      o_Score_L <= score_l_nxt;
      o_Score_R <= score_r_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (serve_go) state_nxt = MOVE;
      MOVE:    if (miss_l || miss_r) state_nxt = MISS;
      MISS:    if (recenter) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    active_nxt  = (state_nxt == MOVE);
    score_r_nxt = miss_l;
    score_l_nxt = miss_r;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      step       <= STEP_W'(1);
      miss_cnt   <= '0;
      loser_left <= 1'b0;
    end else begin
      if (serve_go) step <= (i_Speed == '0) ? STEP_W'(1) : i_Speed;
      if (move_tick && (miss_l || miss_r)) begin
        miss_cnt   <= CNT_W'(MISS_FRAMES - 1);
        loser_left <= miss_l;
      end else if ((state == MISS) && i_Frame_Tick && !miss_done) begin
        miss_cnt <= miss_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: reset, serve, wall bounce, paddle
// hit/miss with miss timeout, and a simultaneous corner bounce.
module tb_ball_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       serve = 1'b0;
  logic [2:0] speed = 3'd0;
  logic       track = 1'b0;
  logic [9:0] pl_fix = 10'd200;
  logic [9:0] pr_fix = 10'd200;
  logic [9:0] pad_l;
  logic [9:0] pad_r;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       hdir;
  logic       vdir;
  logic       active;
  logic       score_l;
  logic       score_r;
  int         errors = 0;
  int         checks = 0;

  // Autopilot keeps both paddles level with the ball so every edge is a hit.
  assign pad_l = track ? ball_y : pl_fix;
  assign pad_r = track ? ball_y : pr_fix;

  always #5 clk = ~clk;

  ball_motion_ctrl dut (
    .i_Clk(clk),
    .i_Reset(rst),
`ifdef DEBUG_DIR_OVERRIDE_EN
    .i_Switch(4'd0),
`endif
    .i_Frame_Tick(tick),
    .i_Serve(serve),
    .i_Speed(speed),
    .i_PaddleL_Y(pad_l),
    .i_PaddleR_Y(pad_r),
    .o_Ball_X(ball_x),
    .o_Ball_Y(ball_y),
    .o_HDir(hdir),
    .o_VDir(vdir),
    .o_Active(active),
    .o_Score_L(score_l),
    .o_Score_R(score_r)
  );

  task automatic do_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic apply_reset();
    track = 1'b0; serve = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic serve_at(input logic [2:0] spd);
    speed = spd; serve = 1'b1;
    do_tick();
    serve = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (ball_x !== 10'd316) begin errors++; $display("FAIL reset_x: got %0d want 316", ball_x); end
    checks++; if (ball_y !== 10'd236) begin errors++; $display("FAIL reset_y: got %0d want 236", ball_y); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b want 0", active); end
    checks++; if (hdir !== 1'b0) begin errors++; $display("FAIL reset_hdir: got %b want 0", hdir); end
    checks++; if (vdir !== 1'b1) begin errors++; $display("FAIL reset_vdir: got %b want 1", vdir); end
    checks++; if ({score_l, score_r} !== 2'b00) begin errors++; $display("FAIL reset_scores: got %b want 00", {score_l, score_r}); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_serve_min_speed();
    speed = 3'd0; serve = 1'b1;
    do_tick();
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL serve_active: got %b want 1", active); end
    checks++; if ({ball_x, ball_y} !== {10'd316, 10'd236}) begin errors++; $display("FAIL serve_no_move: got %0d/%0d want 316/236", ball_x, ball_y); end
    speed = 3'd5;
    do_tick();
    checks++; if ({ball_x, ball_y} !== {10'd317, 10'd235}) begin errors++; $display("FAIL step1_tick1: got %0d/%0d want 317/235", ball_x, ball_y); end
    do_tick();
    checks++; if ({ball_x, ball_y} !== {10'd318, 10'd234}) begin errors++; $display("FAIL step1_tick2: got %0d/%0d want 318/234", ball_x, ball_y); end
    serve = 1'b0;
  endtask

  task automatic test_reset_mid_move();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({ball_x, ball_y} !== {10'd316, 10'd236}) begin errors++; $display("FAIL midreset_pos: got %0d/%0d want 316/236", ball_x, ball_y); end
    checks++; if ({active, hdir, vdir} !== 3'b001) begin errors++; $display("FAIL midreset_flags: got act/h/v=%b want 001", {active, hdir, vdir}); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_top_bounce_right_hit();
    apply_reset();
    pl_fix = 10'd240; pr_fix = 10'd40;
    serve_at(3'd3);
    run_ticks(78);
    checks++; if ({ball_x, ball_y} !== {10'd550, 10'd2}) begin errors++; $display("FAIL pre_top: got %0d/%0d want 550/2", ball_x, ball_y); end
    do_tick();
    checks++; if ({ball_x, ball_y, vdir} !== {10'd553, 10'd0, 1'b0}) begin errors++; $display("FAIL top_clamp: got %0d/%0d v=%b want 553/0 v=0", ball_x, ball_y, vdir); end
    do_tick();
    checks++; if ({ball_x, ball_y} !== {10'd556, 10'd3}) begin errors++; $display("FAIL after_top: got %0d/%0d want 556/3", ball_x, ball_y); end
    run_ticks(22);
    checks++; if ({ball_x, ball_y} !== {10'd622, 10'd69}) begin errors++; $display("FAIL pre_right: got %0d/%0d want 622/69", ball_x, ball_y); end
    do_tick();
    checks++; if ({ball_x, ball_y, hdir} !== {10'd624, 10'd72, 1'b1}) begin errors++; $display("FAIL right_hit: got %0d/%0d h=%b want 624/72 h=1", ball_x, ball_y, hdir); end
    checks++; if ({active, score_l, score_r} !== 3'b100) begin errors++; $display("FAIL right_hit_flags: got act/sl/sr=%b want 100", {active, score_l, score_r}); end
  endtask

  task automatic test_left_hit();
    apply_reset();
    pl_fix = 10'd240; pr_fix = 10'd40;
    serve_at(3'd3);
    run_ticks(308);
    checks++; if ({ball_x, ball_y, hdir, vdir} !== {10'd9, 10'd259, 2'b11}) begin errors++; $display("FAIL pre_left: got %0d/%0d h/v=%b%b want 9/259 h/v=11", ball_x, ball_y, hdir, vdir); end
    do_tick();
    checks++; if ({ball_x, ball_y, hdir} !== {10'd8, 10'd256, 1'b0}) begin errors++; $display("FAIL left_hit: got %0d/%0d h=%b want 8/256 h=0", ball_x, ball_y, hdir); end
    checks++; if ({active, score_l, score_r} !== 3'b100) begin errors++; $display("FAIL left_hit_flags: got act/sl/sr=%b want 100", {active, score_l, score_r}); end
  endtask

  task automatic test_left_miss();
    apply_reset();
    pl_fix = 10'd300; pr_fix = 10'd40;
    serve_at(3'd3);
    run_ticks(309);
    checks++; if ({active, score_l, score_r} !== 3'b001) begin errors++; $display("FAIL left_miss_flags: got act/sl/sr=%b want 001", {active, score_l, score_r}); end
    checks++; if (ball_x !== 10'd9) begin errors++; $display("FAIL left_miss_x: got %0d want 9", ball_x); end
    @(negedge clk);
    checks++; if (score_r !== 1'b0) begin errors++; $display("FAIL score_r_width: got %b want 0", score_r); end
    serve = 1'b1;
    run_ticks(59);
    serve = 1'b0;
    checks++; if ({active, ball_x} !== {1'b0, 10'd9}) begin errors++; $display("FAIL miss_hold: got act=%b x=%0d want act=0 x=9", active, ball_x); end
    do_tick();
    checks++; if ({ball_x, ball_y, hdir, vdir, active} !== {10'd316, 10'd236, 3'b110}) begin errors++; $display("FAIL left_recenter: got %0d/%0d h/v/a=%b%b%b want 316/236 h/v/a=110", ball_x, ball_y, hdir, vdir, active); end
    serve_at(3'd7);
    checks++; if ({active, ball_x} !== {1'b1, 10'd316}) begin errors++; $display("FAIL reserve: got act=%b x=%0d want act=1 x=316", active, ball_x); end
    do_tick();
    checks++; if ({ball_x, ball_y} !== {10'd309, 10'd229}) begin errors++; $display("FAIL reserve_move: got %0d/%0d want 309/229", ball_x, ball_y); end
  endtask

  task automatic test_right_miss();
    apply_reset();
    pl_fix = 10'd240; pr_fix = 10'd300;
    serve_at(3'd7);
    run_ticks(44);
    checks++; if ({ball_x, ball_y, vdir} !== {10'd624, 10'd70, 1'b0}) begin errors++; $display("FAIL pre_right_miss: got %0d/%0d v=%b want 624/70 v=0", ball_x, ball_y, vdir); end
    do_tick();
    checks++; if ({active, score_l, score_r} !== 3'b010) begin errors++; $display("FAIL right_miss_flags: got act/sl/sr=%b want 010", {active, score_l, score_r}); end
    @(negedge clk);
    checks++; if (score_l !== 1'b0) begin errors++; $display("FAIL score_l_width: got %b want 0", score_l); end
    run_ticks(60);
    checks++; if ({ball_x, ball_y, hdir, vdir} !== {10'd316, 10'd236, 2'b00}) begin errors++; $display("FAIL right_recenter: got %0d/%0d h/v=%b%b want 316/236 h/v=00", ball_x, ball_y, hdir, vdir); end
  endtask

  task automatic test_corner();
    apply_reset();
    track = 1'b1;
    serve_at(3'd7);
    run_ticks(5473);
    checks++; if ({ball_x, ball_y, hdir, vdir, active} !== {10'd8, 10'd3, 3'b111}) begin errors++; $display("FAIL pre_corner: got %0d/%0d h/v/a=%b%b%b want 8/3 h/v/a=111", ball_x, ball_y, hdir, vdir, active); end
    do_tick();
    checks++; if ({ball_x, ball_y, hdir, vdir} !== {10'd8, 10'd0, 2'b00}) begin errors++; $display("FAIL corner: got %0d/%0d h/v=%b%b want 8/0 h/v=00", ball_x, ball_y, hdir, vdir); end
    checks++; if ({active, score_l, score_r} !== 3'b100) begin errors++; $display("FAIL corner_flags: got act/sl/sr=%b want 100", {active, score_l, score_r}); end
    do_tick();
    checks++; if ({ball_x, ball_y} !== {10'd15, 10'd7}) begin errors++; $display("FAIL after_corner: got %0d/%0d want 15/7", ball_x, ball_y); end
    track = 1'b0;
  endtask

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_serve_min_speed();
    test_reset_mid_move();
    test_top_bounce_right_hit();
    test_left_hit();
    test_left_miss();
    test_right_miss();
    test_corner();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
- Parametrised successor to the bounce/direction logic.
- Owns the ball's X/Y position counters, per-axis direction and step size, and detects wall and paddle collisions.
- Runs the serve/play/miss state machine and emits score pulses.
- Sits between the VGA sync/frame-tick generator and the ball/paddle renderers; all updates happen once per frame.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
COORD_W, 10, width of coordinate buses
BALL_SIZE, 8, ball edge length in pixels
PADDLE_W, 8, paddle column width; left paddle at x=[0,PADDLE_W), right paddle at x=[H_ACTIVE-PADDLE_W,H_ACTIVE)
PADDLE_H, 64, paddle height in lines
STEP_W, 3, width of speed input
MISS_FRAMES, 60, frames the ball stays hidden after a miss

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  asynchronous, active-high reset
i_Frame_Tick  in  1  single-cycle pulse, once per frame (start of vertical blank)
i_Serve  in  1  level; launch the ball while in IDLE
i_Speed  in  STEP_W  pixels per frame per axis, sampled at serve
i_PaddleL_Y  in  COORD_W  top line of left paddle
i_PaddleR_Y  in  COORD_W  top line of right paddle
o_Ball_X  out  COORD_W  ball left column
o_Ball_Y  out  COORD_W  ball top line
o_HDir  out  1  0=RIGHT, 1=LEFT
o_VDir  out  1  0=DOWN, 1=UP
o_Active  out  1  ball visible/in play
o_Score_L  out  1  one-cycle pulse, left player scored
o_Score_R  out  1  one-cycle pulse, right player scored

Behaviour:
- Reset (async, immediate, also mid-play):
  - State IDLE; X=CX=(H_ACTIVE-BALL_SIZE)/2 (316); Y=CY=(V_ACTIVE-BALL_SIZE)/2 (236).
  - HDir=RIGHT, VDir=UP, o_Active=0, score pulses 0, step register=1, miss counter 0.
- All outputs are registered. Updates take effect on the first i_Clk edge where i_Frame_Tick=1. No other cycle changes position.
- IDLE:
  - Ball centred; o_Active=0.
  - On a tick with i_Serve=1: latch step=(i_Speed==0 ? 1 : i_Speed), set o_Active=1, go to MOVE. Position does not move on the serve tick.
- MOVE, each tick, both axes evaluated independently in the same tick (corner hit = both bounce):
  - Vertical UP: if Y<step then Y=0, VDir=DOWN; else Y=Y-step.
  - Vertical DOWN: if Y+step > V_ACTIVE-BALL_SIZE then Y=V_ACTIVE-BALL_SIZE, VDir=UP; else Y=Y+step.
  - Horizontal LEFT, if X-step < PADDLE_W (computed without underflow):
    - Overlap (Y+BALL_SIZE > i_PaddleL_Y and Y < i_PaddleL_Y+PADDLE_H): X=PADDLE_W, HDir=RIGHT.
    - Otherwise: o_Score_R pulses, go to MISS.
  - Horizontal RIGHT, if X+step > H_ACTIVE-PADDLE_W-BALL_SIZE: mirror of LEFT using i_PaddleR_Y.
    - Hit: X=H_ACTIVE-PADDLE_W-BALL_SIZE, HDir=LEFT.
    - Miss: o_Score_L pulses.
  - Otherwise X moves by step.
  - Overlap uses the pre-update Y. Comparisons use COORD_W+1 bits.
- MISS:
  - o_Active=0; X/Y frozen; counter loads MISS_FRAMES-1 on entry and decrements per tick.
  - At 0: X=CX, Y=CY, HDir points toward the player who missed (serve to loser), VDir unchanged; go to IDLE.
- Score pulses are high for exactly one i_Clk cycle. Never both in the same cycle.
- i_Serve is ignored outside IDLE. i_Speed changes take effect only at the next serve.

Optional Feature:
DEBUG_DIR_OVERRIDE_EN
- Defined:
  - Adds port i_Switch (in, 4) for development direction override.
  - On any tick in MOVE, a set bit forces the direction after collision logic, overriding any bounce direction from the same tick. Priority is bit3 highest.
  - bit0 = LEFT/UP, bit1 = LEFT/DOWN, bit2 = RIGHT/UP, bit3 = RIGHT/DOWN.
  - Position clamping still applies.
- Undefined: port absent; directions come only from collisions and serve.

Decomposition:
- Package pong_pkg holds:
  - Direction localparams DIR_RIGHT=0, DIR_LEFT=1, DIR_DOWN=0, DIR_UP=1.
  - State encoding IDLE/MOVE/MISS.
  - Shared geometry defaults (H_ACTIVE, V_ACTIVE, BALL_SIZE, PADDLE_W, PADDLE_H).
- One sub-module, axis_stepper: one axis's position, direction, clamp and edge-detect. Instantiated twice.
- Paddle overlap and the FSM stay in the top.

Test Plan:
1. Reset mid-MOVE (X=100) -> same cycle: X=316, Y=236, o_Active=0, HDir=0, VDir=1.
2. IDLE, i_Serve=1, i_Speed=0, three ticks -> step=1; after ticks X=316→317→318, Y=236→235→234.
3. Top bounce: Y=2, VDir=UP, step=4, tick -> Y=0, VDir=DOWN; next tick Y=4.
4. Left paddle hit: X=10, HDir=LEFT, step=4, Y=100, i_PaddleL_Y=80 -> X=8, HDir=RIGHT, no score pulse.
5. Left miss: same but i_PaddleL_Y=300 -> o_Score_R one-cycle pulse, o_Active=0. After 60 ticks ball at 316/236 in IDLE with HDir=LEFT.
6. Corner: X=626, Y=470, RIGHT/DOWN, step=4, i_PaddleR_Y=440 -> X=624, Y=472, HDir=LEFT, VDir=UP in the same tick.
